// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional byte-lane stores are enabled with `define DMEM_BYTE_EN.
package dmem_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;
   localparam int CNT_W  = 4;

   localparam logic [WORD_W-1:0] ZERO_DATA = '0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic              write;
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } req_t;

endpackage

// File: rtl/dmem_storage_array.sv
// Word storage with per-byte write enables, registered read
// port and synchronous clear of every word.
module dmem_storage_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 128
) (
   input  logic                           clk,
   input  logic                           clr,
   input  logic [BE_W-1:0]                we,
   input  logic                           re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [WORD_W-1:0]              wdata,
   output logic [WORD_W-1:0]              rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
         rdata <= ZERO_DATA;
      end else begin
         for (int b = 0; b < BE_W; b++) begin
            if (we[b]) begin
               mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         if (re) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder with programmable wait states.
// Define DMEM_BYTE_EN to add the req_be_i byte-lane store port.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [WORD_W-1:0] req_addr_i,
   input  logic [WORD_W-1:0] req_wdata_i,
`ifdef DMEM_BYTE_EN
   input  logic [BE_W-1:0]   req_be_i,
`endif
   output logic              resp_valid_o,
   output logic [WORD_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic              stall_o
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   req_t              lat, cur;
   logic [BE_W-1:0]   be_in, we;
   logic              accept, commit, err, re;
   logic              misalign, oor;
   logic              rd_ok, err_q;
   logic [AW-1:0]     idx;
   logic [WORD_W-1:0] rd_q;

`ifdef DMEM_BYTE_EN
   assign be_in = req_be_i;
`else
   assign be_in = '1;
`endif

   assign accept = req_valid_i & (state == IDLE);

   // In IDLE the live inputs are used so a zero-wait access can
   // commit on its own acceptance edge.
   always_comb begin
      cur = lat;
      if (state == IDLE) begin
         cur.write = req_write_i;
         cur.addr  = req_addr_i;
         cur.wdata = req_wdata_i;
         cur.be    = be_in;
      end
   end

   always_comb begin
      commit = 1'b0;
      unique case (1'b1)
         (state == IDLE): commit = accept && (WAIT_CYCLES == 0);
         (state == WAIT): commit = (cnt == CNT_W'(1));
         default:         commit = 1'b0;
      endcase
   end

   assign misalign = (cur.addr[1:0] != 2'b00) && (cur.be == '1);
   assign oor      = {2'b00, cur.addr[WORD_W-1:2]} >= 32'(DEPTH_WORDS);
   assign err      = misalign | oor;
   assign idx      = cur.addr[AW+1:2];

   assign we = (commit & cur.write & ~err & ~rst_i) ? cur.be : '0;
   assign re = commit & ~cur.write & ~err;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cnt_nx   = WAIT_INIT;
               state_nx = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_nx = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_nx = RESP;
            end
         end
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
         lat   <= '0;
         rd_ok <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            lat <= cur;
         end
         if (commit) begin
            rd_ok <= ~cur.write & ~err;
            err_q <= err;
         end
      end
   end

   dmem_storage_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_store (
      .clk   (clk_i),
      .clr   (rst_i),
      .we    (we),
      .re    (re),
      .addr  (idx),
      .wdata (cur.wdata),
      .rdata (rd_q)
   );

   assign req_ready_o  = (state == IDLE);
   assign resp_valid_o = (state == RESP);
   assign resp_rdata_o = rd_ok ? rd_q : ZERO_DATA;
   assign resp_err_o   = err_q;
   assign stall_o      = req_valid_i & ~resp_valid_o;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU's MEM-stage load/store interface.
- Accepts one load or store request at a time through a valid/ready handshake and applies a programmable number of wait states.
- Returns a one-cycle response carrying read data and an error flag.
- Drives a stall signal so the pipeline holds its EX/MEM contents until the access completes.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words of storage; must be a power of two, at least 2.
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.

Ports:
- clk_i  input  1  single clock; all logic is on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  1  MEM stage presents a request (MemRead or MemWrite asserted).
- req_ready_o  output  1  responder can accept a request this cycle.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address (ALU result).
- req_wdata_i  input  32  store data (RT value).
- resp_valid_o  output  1  one-cycle pulse: access complete.
- resp_rdata_o  output  32  load data; 0 for stores and errors.
- resp_err_o  output  1  qualified by resp_valid_o; misaligned or out-of-range access.
- stall_o  output  1  pipeline freeze request.

Behaviour:
- Reset (rst_i high at an edge):
  - state goes to IDLE; wait counter goes to 0.
  - resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0.
  - All storage words are cleared to 0.
  - Reset has priority over every other event.
- FSM states: IDLE, WAIT, RESP.
  - req_ready_o = 1 only in IDLE.
  - IDLE: accept on req_valid_i & req_ready_o. At that edge, latch write, addr and wdata, and load counter = WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES > 0, otherwise RESP.
  - WAIT: decrement the counter each cycle. Move to RESP on the edge where counter == 1.
  - RESP: resp_valid_o = 1 for exactly one cycle, then IDLE unconditionally. A request is never accepted in RESP.
- Latency and throughput:
  - Acceptance edge at cycle 0; resp_valid_o is high during cycle WAIT_CYCLES+1.
  - Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Commit point:
  - A store writes storage on the edge entering RESP.
  - A load samples storage on that same edge into resp_rdata_o, which holds its value until the next RESP.
- Inputs after acceptance are ignored (latched copy is used). The requester holds the request stable while stall_o = 1.
- stall_o = req_valid_i & ~resp_valid_o (combinational). With req_valid_i low, stall_o = 0.
- Word index is the latched addr[log2(DEPTH_WORDS)+1:2].
- Error cases: addr[1:0] != 0, or addr[31:2] >= DEPTH_WORDS.
  - On error: no storage write, resp_rdata_o = 0, resp_err_o = 1.
  - Otherwise resp_err_o = 0.
- Reset mid-operation (in WAIT or RESP): the pending access is discarded and no store commits.
- A load to the same word as an immediately preceding store returns the new data.

Optional Feature:
- Macro: DMEM_BYTE_EN.
- With it defined:
  - Adds port req_be_i (input, 4 bits), latched at acceptance.
  - A store updates only the byte lanes whose enable bit is 1; bit n maps to bits 8n+7:8n.
  - Alignment check requires addr[1:0] == 0 only when req_be_i == 4'b1111. Partial enables may use any addr[1:0].
  - req_be_i == 0 on a store: response with no write and no error.
  - Loads ignore req_be_i.
- Without it: no req_be_i port; every store writes the full word.

Decomposition:
- Package dmem_pkg:
  - state encoding (IDLE, WAIT, RESP) as a typedef.
  - WORD_W = 32, BE_W = 4, CNT_W = 4.
  - constant for the zero response data.
- Sub-module dmem_storage_array:
  - DEPTH_WORDS x 32 synchronous-write, synchronous-read array with per-byte write enables and synchronous clear.
  - dmem_responder instantiates it; the FSM, counter and checks stay in the top.

Test Plan:
- Reset, then store 0xDEADBEEF to 0x10 with WAIT_CYCLES=2 → req_ready_o drops after the acceptance edge; stall_o high cycles 0..2; resp_valid_o high cycle 3 only; resp_err_o = 0.
- Load from 0x10 → resp_rdata_o = 0xDEADBEEF in cycle 3. Load from 0x14 → 0x00000000.
- Load from 0x13 (misaligned) and from 0x200 (word 128, out of range) → resp_err_o = 1, resp_rdata_o = 0; storage unchanged, verified by reloading 0x10.
- Store 0x12345678 to 0x20, assert rst_i during WAIT → no resp_valid_o; after reset, a load from 0x20 returns 0.
- WAIT_CYCLES=0 build: store then load at 0x04 → resp_valid_o in cycle 1 after each acceptance; readback matches.
- DMEM_BYTE_EN: store 0xFFFFFFFF to 0x08 (be=1111), then store 0x000000AA with be=0001 → readback 0xFFFFFFAA. Store with be=0000 → readback unchanged, resp_err_o = 0.
